nh_lcd_data_reader: RTL and testbench
=====================================

Name: nh_lcd_data_reader

Overview:
- Reads a frame of pixels back from the NH LCD controller over the 8-bit parallel bus, the read-side counterpart of the pixel writer.
- Issues the memory-read command (0x2E), discards the mandatory dummy byte, then reads R, G, B bytes per pixel.
- Packs each pixel as {8'h00,R,G,B} into an internal ping-pong FIFO (ppfifo) whose read side is exported to the host/wishbone layer.

Parameters:
BUFFER_SIZE, 12, ppfifo ADDRESS_WIDTH (depth 2^BUFFER_SIZE words per side)
READ_DELAY, 2, clk cycles from o_read pulse to sampling i_data (range 0..15)

Ports:
clk  input  1  clock (also ppfifo read and write clock)
rst  input  1  synchronous, active-high reset
debug  output  8  debug bus (see Optional Feature)
i_enable  input  1  start/continue frame readback; deassert aborts
i_num_pixels  input  32  pixels per frame
o_frame_done  output  1  one-cycle pulse when the last pixel has been pushed
o_fifo_rdy  output  2  ppfifo read_ready
i_fifo_act  input  1  ppfifo read_activate
i_fifo_stb  input  1  ppfifo read_strobe
o_fifo_size  output  24  ppfifo read_count
o_fifo_data  output  32  ppfifo read_data
o_data_cmd_mode  output  1  1 = command byte on bus, 0 = data
o_data_out_en  output  1  1 = block drives o_data onto the bus
o_data  output  8  command byte to the LCD
i_data  input  8  byte read from the LCD
o_write  output  1  write strobe, one-cycle pulse
o_read  output  1  read strobe, one-cycle pulse

Behaviour:
- Reset: all outputs 0; state IDLE; pixel, word and delay counters 0; FIFO write side released (act=0).
- FIFO acquire (every cycle, any state): if write_ready!=0 and act==0, then act<=2'b01 when rdy[0], else 2'b10; word count<=0.
- IDLE:
  - If i_enable && i_num_pixels!=0 && act!=0: o_data_out_en<=1, o_data_cmd_mode<=1, o_data<=8'h2E, o_write<=1, pixel count<=0, go CMD.
- CMD: o_data_out_en<=0, o_data_cmd_mode<=0; go DUMMY_START.
- DUMMY_START / RED_START / GREEN_START / BLUE_START:
  - o_read<=1, delay<=READ_DELAY; go matching _WAIT.
- _WAIT:
  - If delay!=0, decrement.
  - Else sample i_data: dummy discarded; R/G/B latched.
  - Next state: DUMMY->RED_START, RED->GREEN_START, GREEN->BLUE_START, BLUE->PUSH.
  - Sample point is READ_DELAY+1 cycles after the o_read pulse.
- PUSH:
  - Stall with no bus activity while act==0.
  - Otherwise: write_strobe<=1, data={8'h00,R,G,B}, word count+1, pixel count+1.
  - If word count+1 == write_fifo_size, release act (<=0).
  - If pixel count+1 == i_num_pixels: release act, pulse o_frame_done, go IDLE.
  - Else go RED_START.
  - Bus reads stay sequential; no LCD re-command between FIFO swaps.
- Abort: i_enable low in any non-IDLE state:
  - Go IDLE next cycle.
  - Release act if word count!=0 (partial data flushed).
  - Drop o_read/o_write; no o_frame_done.
- o_write and o_read are never asserted in the same cycle; each is a 1-cycle pulse.
- Pixel count is 32-bit and never wraps (compared with ==).
- Word count is 24-bit and compared against the write_fifo_size sampled at activation.
- Reset mid-frame: immediate return to reset values; ppfifo reset concurrently.

Optional Feature:
- Macro NH_LCD_READER_DEBUG_EN.
- Defined: debug = {o_frame_done, act[1:0], enable, state[3:0]}.
- Undefined: debug = 8'h00, and no debug logic is synthesized.

Test Plan:
- Reset, then idle with i_enable=0 -> all outputs 0, no o_read/o_write for 100 cycles.
- i_num_pixels=2, READ_DELAY=2, LCD model returns 0xFF (dummy), 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 -> o_write once with o_data 0x2E and cmd_mode 1; exactly 7 o_read pulses, 3 cycles to each sample; host reads 0x00112233, 0x00445566; one o_frame_done.
- BUFFER_SIZE=2 (4 words), i_num_pixels=10 -> FIFOs fill 4,4,2; the reader stalls in PUSH while the host withholds reads; all 10 words are returned in order.
- i_num_pixels=0 with i_enable=1 -> no bus activity, no o_frame_done.
- Drop i_enable after pixel 3 of 8 -> IDLE within 1 cycle; 3 words are delivered; no o_frame_done; a re-enable restarts with the 0x2E command.
- Assert rst during GREEN_WAIT -> next cycle all outputs 0; the following frame completes correctly.

Source files
------------

// File: rtl/nh_lcd_data_reader_if.sv
// Bus bundle for nh_lcd_data_reader: frame control, ping-pong FIFO read side
// toward the host, and the 8-bit parallel LCD bus.
// The master modport is the reader itself; the slave modport is the
// surrounding host/LCD environment.
interface nh_lcd_data_reader_if;
    logic [7:0]  debug;
    logic        i_enable;
    logic [31:0] i_num_pixels;
    logic        o_frame_done;
    logic [1:0]  o_fifo_rdy;
    logic        i_fifo_act;
    logic        i_fifo_stb;
    logic [23:0] o_fifo_size;
    logic [31:0] o_fifo_data;
    logic        o_data_cmd_mode;
    logic        o_data_out_en;
    logic [7:0]  o_data;
    logic [7:0]  i_data;
    logic        o_write;
    logic        o_read;

    modport master (
        output debug,
        input  i_enable, i_num_pixels,
        output o_frame_done,
        output o_fifo_rdy,
        input  i_fifo_act, i_fifo_stb,
        output o_fifo_size, o_fifo_data,
        output o_data_cmd_mode, o_data_out_en, o_data,
        input  i_data,
        output o_write, o_read
    );

    modport slave (
        input  debug,
        output i_enable, i_num_pixels,
        input  o_frame_done,
        input  o_fifo_rdy,
        output i_fifo_act, i_fifo_stb,
        input  o_fifo_size, o_fifo_data,
        input  o_data_cmd_mode, o_data_out_en, o_data,
        output i_data,
        input  o_write, o_read
    );
endinterface

// File: rtl/nh_lcd_data_reader.sv
// nh_lcd_data_reader: reads a frame back from the NH LCD controller.
// Sends the 0x2E memory-read command, throws away the dummy byte, then reads
// R, G, B per pixel and packs {8'h00,R,G,B} into an internal ping-pong FIFO
// whose read side is exported to the host.
// Optional debug bus: define NH_LCD_READER_DEBUG_EN to expose
// {frame_done, fifo write activate, enable, state}; otherwise debug is 0.
module nh_lcd_data_reader #(
    parameter int BUFFER_SIZE = 12,
    parameter int READ_DELAY  = 2
) (
    input logic clk,
    input logic rst,
    nh_lcd_data_reader_if.master bus
);
    localparam int          DEPTH      = 1 << BUFFER_SIZE;
    localparam logic [23:0] FIFO_SIZE  = 24'(DEPTH);
    localparam logic [3:0]  DELAY_INIT = 4'(READ_DELAY);

    // Each _WAIT state directly follows its _START state in this encoding.
    typedef enum logic [3:0] {
        IDLE, CMD,
        DUMMY_START, DUMMY_WAIT,
        RED_START, RED_WAIT,
        GREEN_START, GREEN_WAIT,
        BLUE_START, BLUE_WAIT,
        PUSH
    } state_t;

    state_t      state;
    logic [31:0] pixel_count;
    logic [23:0] word_count;
    logic [23:0] fifo_size_q;
    logic [3:0]  delay;
    logic [7:0]  red, green, blue;
    logic        frame_done, data_cmd_mode, data_out_en, write_pulse, read_pulse;
    logic [7:0]  data_out;

    logic [1:0]  wr_act, wr_act_q, wr_ready, filled;
    logic        wr_stb, wr_sel_q;
    logic [31:0] wr_data;
    logic [BUFFER_SIZE:0] wr_count [2];
    logic        rd_sel, rd_active;
    logic [BUFFER_SIZE:0] rd_ptr;
    logic [31:0] mem [2*DEPTH];

    // A buffer is offered to the writer only once it is empty and fully released.
    assign wr_ready = ~filled & ~wr_act & ~wr_act_q;
    assign wr_sel_q = wr_act_q[1];

    // Command/readback sequencer plus acquisition of a FIFO write buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pixel_count   <= '0;
            word_count    <= '0;
            fifo_size_q   <= '0;
            delay         <= '0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            frame_done    <= 1'b0;
            data_cmd_mode <= 1'b0;
            data_out_en   <= 1'b0;
            data_out      <= '0;
            write_pulse   <= 1'b0;
            read_pulse    <= 1'b0;
            wr_act        <= '0;
            wr_stb        <= 1'b0;
            wr_data       <= '0;
        end else begin
            write_pulse <= 1'b0;
            read_pulse  <= 1'b0;
            frame_done  <= 1'b0;
            wr_stb      <= 1'b0;
            if (wr_ready != 2'b00 && wr_act == 2'b00) begin
                wr_act      <= wr_ready[0] ? 2'b01 : 2'b10;
                word_count  <= '0;
                fifo_size_q <= FIFO_SIZE;
            end
            if (state != IDLE && !bus.i_enable) begin
                state         <= IDLE;
                data_out_en   <= 1'b0;
                data_cmd_mode <= 1'b0;
                if (word_count != '0) wr_act <= 2'b00;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.i_enable && bus.i_num_pixels != '0 && wr_act != 2'b00) begin
                            data_out_en   <= 1'b1;
                            data_cmd_mode <= 1'b1;
                            data_out      <= 8'h2E;
                            write_pulse   <= 1'b1;
                            pixel_count   <= '0;
                            state         <= CMD;
                        end
                    end
                    CMD: begin
                        data_out_en   <= 1'b0;
                        data_cmd_mode <= 1'b0;
                        state         <= DUMMY_START;
                    end
                    DUMMY_START, RED_START, GREEN_START, BLUE_START: begin
                        read_pulse <= 1'b1;
                        delay      <= DELAY_INIT;
                        state      <= state_t'(state + 4'd1);
                    end
                    DUMMY_WAIT, RED_WAIT, GREEN_WAIT, BLUE_WAIT: begin
                        if (delay != 4'd0) begin
                            delay <= delay - 4'd1;
                        end else begin
                            case (state)
                                RED_WAIT:   red   <= bus.i_data;
                                GREEN_WAIT: green <= bus.i_data;
                                BLUE_WAIT:  blue  <= bus.i_data;
                                default:    ;
                            endcase
                            state <= (state == BLUE_WAIT) ? PUSH : state_t'(state + 4'd1);
                        end
                    end
                    PUSH: begin
                        if (wr_act != 2'b00) begin
                            wr_stb      <= 1'b1;
                            wr_data     <= {8'h00, red, green, blue};
                            word_count  <= word_count + 24'd1;
                            pixel_count <= pixel_count + 32'd1;
                            if (word_count + 24'd1 == fifo_size_q) wr_act <= 2'b00;
                            if (pixel_count + 32'd1 == bus.i_num_pixels) begin
                                wr_act     <= 2'b00;
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= RED_START;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Ping-pong bookkeeping: fill counts, commit on write release, host read side.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_act_q    <= '0;
            filled      <= '0;
            wr_count[0] <= '0;
            wr_count[1] <= '0;
            rd_sel      <= 1'b0;
            rd_active   <= 1'b0;
            rd_ptr      <= '0;
        end else begin
            wr_act_q <= wr_act;
            if (wr_stb && wr_act_q != 2'b00)
                wr_count[wr_sel_q] <= wr_count[wr_sel_q] + 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (wr_act_q[i] && !wr_act[i] && (wr_count[i] != '0 || wr_stb))
                    filled[i] <= 1'b1;
            end
            if (!rd_active) begin
                rd_ptr <= '0;
                if (bus.i_fifo_act && filled[rd_sel]) rd_active <= 1'b1;
            end else if (!bus.i_fifo_act) begin
                rd_active        <= 1'b0;
                filled[rd_sel]   <= 1'b0;
                wr_count[rd_sel] <= '0;
                rd_sel           <= ~rd_sel;
            end else if (bus.i_fifo_stb && rd_ptr < wr_count[rd_sel]) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Pixel storage for both halves of the ping-pong buffer.
    always_ff @(posedge clk) begin
        if (wr_stb && wr_act_q != 2'b00)
            mem[{wr_sel_q, wr_count[wr_sel_q][BUFFER_SIZE-1:0]}] <= wr_data;
    end

    assign bus.o_fifo_rdy      = {filled[1] & ~rd_active & rd_sel, filled[0] & ~rd_active & ~rd_sel};
    assign bus.o_fifo_size     = rd_active ? 24'(wr_count[rd_sel]) : 24'd0;
    assign bus.o_fifo_data     = rd_active ? mem[{rd_sel, rd_ptr[BUFFER_SIZE-1:0]}] : 32'd0;
    assign bus.o_frame_done    = frame_done;
    assign bus.o_data_cmd_mode = data_cmd_mode;
    assign bus.o_data_out_en   = data_out_en;
    assign bus.o_data          = data_out;
    assign bus.o_write         = write_pulse;
    assign bus.o_read          = read_pulse;

`ifdef NH_LCD_READER_DEBUG_EN
    assign bus.debug = {frame_done, wr_act, bus.i_enable, state};
`else
    assign bus.debug = 8'h00;
`endif
endmodule

// File: tb/tb_nh_lcd_data_reader.sv
// Bench for nh_lcd_data_reader: an LCD model that returns queued bytes only in
// the sampling window, a host that drains the ping-pong FIFO, and a pixel
// reference built from the queued bytes.
module tb_nh_lcd_data_reader;
    localparam int BUFFER_SIZE = 2;
    localparam int READ_DELAY  = 2;
    localparam int DEPTH       = 1 << BUFFER_SIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;

    nh_lcd_data_reader_if bus();

    nh_lcd_data_reader #(
        .BUFFER_SIZE(BUFFER_SIZE),
        .READ_DELAY (READ_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int read_pulses = 0;
    int write_pulses = 0;
    int done_pulses = 0;
    logic [7:0]  lcd_q [$];
    logic [31:0] exp_q [$];
    logic        lcd_pending = 1'b0;
    int          lcd_left = 0;
    logic [7:0]  lcd_byte = 8'h00;
    logic        prev_read = 1'b0;
    logic        prev_write = 1'b0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] outVec();
        return 128'({bus.debug, bus.o_frame_done, bus.o_fifo_rdy, bus.o_fifo_size, bus.o_fifo_data,
                     bus.o_data_cmd_mode, bus.o_data_out_en, bus.o_data, bus.o_write, bus.o_read});
    endfunction

    // LCD model (valid byte only at the sampling point) and bus pulse monitor.
    always @(negedge clk) begin
        if (rst) begin
            lcd_pending = 1'b0;
        end else if (bus.o_read) begin
            lcd_pending = 1'b1;
            lcd_left    = READ_DELAY;
            if (lcd_q.size() != 0) lcd_byte = lcd_q.pop_front();
            else lcd_byte = 8'($urandom);
        end else if (lcd_pending) begin
            if (lcd_left == 0) lcd_pending = 1'b0;
            else lcd_left--;
        end
        bus.i_data = (lcd_pending && lcd_left == 0) ? lcd_byte : (lcd_byte ^ 8'($urandom_range(1, 255)));
        if (!rst) begin
            if (bus.o_read) begin
                read_pulses++;
                checkOutput("read_excl_write", 128'(bus.o_write), 128'(0));
                checkOutput("read_pulse_width", 128'(prev_read), 128'(0));
            end
            if (bus.o_write) begin
                write_pulses++;
                checkOutput("write_cmd", 128'({bus.o_data_out_en, bus.o_data_cmd_mode, bus.o_data}),
                            128'({1'b1, 1'b1, 8'h2E}));
                checkOutput("write_pulse_width", 128'(prev_write), 128'(0));
            end
            if (bus.o_frame_done) done_pulses++;
        end
        prev_read  = bus.o_read;
        prev_write = bus.o_write;
    end

    // Reference: dummy byte then R,G,B per pixel; first 'keep' pixels are expected out.
    task automatic loadFrame(input int n, input int keep);
        logic [7:0] r, g, b;
        lcd_q.push_back(8'($urandom));
        for (int p = 0; p < n; p++) begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            lcd_q.push_back(r); lcd_q.push_back(g); lcd_q.push_back(b);
            if (p < keep) exp_q.push_back({8'h00, r, g, b});
        end
    endtask

    task automatic applyStimulus(input int n);
        bus.i_num_pixels = 32'(n);
        bus.i_enable     = 1'b1;
    endtask

    task automatic waitDone(input int budget);
        int  c = 0;
        bit  seen = 1'b0;
        while (!seen && c < budget) begin
            @(negedge clk);
            c++;
            if (bus.o_frame_done) seen = 1'b1;
        end
        bus.i_enable = 1'b0;
        checkOutput("frame_done_seen", 128'(seen), 128'(1));
    endtask

    task automatic waitReads(input int n);
        int seen = 0;
        int c = 0;
        while (seen < n && c < 2000) begin
            @(negedge clk);
            c++;
            if (bus.o_read) seen++;
        end
        checkOutput("reads_reached", 128'(seen), 128'(n));
    endtask

    // Host: whenever a buffer is ready, take it, check its size and every word.
    task automatic drainWords(input int n);
        int got = 0;
        int budget = 0;
        int size;
        logic [31:0] expw;
        while (got < n && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (bus.o_fifo_rdy != 2'b00) begin
                bus.i_fifo_act = 1'b1;
                @(negedge clk);
                size = int'(bus.o_fifo_size);
                checkOutput("fifo_size", 128'(size), 128'(((n - got) < DEPTH) ? (n - got) : DEPTH));
                for (int k = 0; k < size && k < 16; k++) begin
                    if (exp_q.size() != 0) expw = exp_q.pop_front();
                    else expw = 32'hDEAD_BEEF;
                    checkOutput("fifo_word", 128'(bus.o_fifo_data), 128'(expw));
                    got++;
                    bus.i_fifo_stb = 1'b1;
                    @(negedge clk);
                    bus.i_fifo_stb = 1'b0;
                end
                bus.i_fifo_act = 1'b0;
            end
        end
        checkOutput("words_drained", 128'(got), 128'(n));
    endtask

    // Directed sequence of scenarios.
    initial begin
        int r0, w0, d0;
        bus.i_enable     = 1'b0;
        bus.i_num_pixels = 32'd0;
        bus.i_fifo_act   = 1'b0;
        bus.i_fifo_stb   = 1'b0;
        bus.i_data       = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", outVec(), 128'(0));
        rst = 1'b0;
        r0 = read_pulses; w0 = write_pulses; d0 = done_pulses;
        repeat (100) @(negedge clk);
        checkOutput("idle_reads", 128'(read_pulses - r0), 128'(0));
        checkOutput("idle_writes", 128'(write_pulses - w0), 128'(0));
        checkOutput("idle_outputs", outVec(), 128'(0));

        $display("[TB] two-pixel frame with known bytes");
        lcd_q = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.push_back(32'h0011_2233);
        exp_q.push_back(32'h0044_5566);
        r0 = read_pulses; w0 = write_pulses; d0 = done_pulses;
        applyStimulus(2);
        fork
            waitDone(2000);
            drainWords(2);
        join
        repeat (10) @(negedge clk);
        checkOutput("f2_reads", 128'(read_pulses - r0), 128'(7));
        checkOutput("f2_writes", 128'(write_pulses - w0), 128'(1));
        checkOutput("f2_done", 128'(done_pulses - d0), 128'(1));

        $display("[TB] ten pixels through a four-word ping-pong with host stalled");
        lcd_q.delete(); exp_q.delete();
        loadFrame(10, 10);
        r0 = read_pulses; w0 = write_pulses; d0 = done_pulses;
        applyStimulus(10);
        repeat (250) @(negedge clk);
        checkOutput("stall_reads", 128'(read_pulses - r0), 128'(1 + 9 * 3));
        checkOutput("stall_no_done", 128'(done_pulses - d0), 128'(0));
        fork
            waitDone(3000);
            drainWords(10);
        join
        repeat (10) @(negedge clk);
        checkOutput("f10_reads", 128'(read_pulses - r0), 128'(1 + 10 * 3));
        checkOutput("f10_done", 128'(done_pulses - d0), 128'(1));

        $display("[TB] zero-pixel frame");
        r0 = read_pulses; w0 = write_pulses; d0 = done_pulses;
        applyStimulus(0);
        repeat (50) @(negedge clk);
        bus.i_enable = 1'b0;
        checkOutput("zero_reads", 128'(read_pulses - r0), 128'(0));
        checkOutput("zero_writes", 128'(write_pulses - w0), 128'(0));
        checkOutput("zero_done", 128'(done_pulses - d0), 128'(0));

        $display("[TB] abort after third pixel of eight");
        lcd_q.delete(); exp_q.delete();
        loadFrame(8, 3);
        d0 = done_pulses;
        applyStimulus(8);
        waitReads(1 + 3 * 3 + 1);
        bus.i_enable = 1'b0;
        @(negedge clk);
        r0 = read_pulses; w0 = write_pulses;
        repeat (30) @(negedge clk);
        checkOutput("abort_reads", 128'(read_pulses - r0), 128'(0));
        checkOutput("abort_writes", 128'(write_pulses - w0), 128'(0));
        checkOutput("abort_no_done", 128'(done_pulses - d0), 128'(0));
        drainWords(3);
        lcd_q.delete(); exp_q.delete();
        loadFrame(2, 2);
        w0 = write_pulses;
        applyStimulus(2);
        fork
            waitDone(2000);
            drainWords(2);
        join
        repeat (5) @(negedge clk);
        checkOutput("restart_writes", 128'(write_pulses - w0), 128'(1));

        $display("[TB] reset during green wait");
        lcd_q.delete(); exp_q.delete();
        loadFrame(3, 0);
        applyStimulus(3);
        waitReads(3);
        rst = 1'b1;
        bus.i_enable = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid_frame", outVec(), 128'(0));
        rst = 1'b0;
        lcd_q.delete(); exp_q.delete();
        repeat (3) @(negedge clk);
        loadFrame(2, 2);
        w0 = write_pulses; d0 = done_pulses;
        applyStimulus(2);
        fork
            waitDone(2000);
            drainWords(2);
        join
        repeat (5) @(negedge clk);
        checkOutput("post_reset_writes", 128'(write_pulses - w0), 128'(1));
        checkOutput("post_reset_done", 128'(done_pulses - d0), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end
endmodule
